input_fifo_stage: RTL

Registered 8-bit buffering stage placed directly upstream of the byte bypass stage. It accepts bytes from a producer with a valid/ready handshake, stores up to DEPTH bytes, and presents the oldest byte on Output_Data, which feeds the bypass stage's 8-bit data input. It decouples producer bursts from consumer stalls and gives the datapath a clean registered boundary.

---
 rtl/input_fifo_stage.sv | 76 +++++++
 1 files changed

// File: rtl/input_fifo_stage.sv
// input_fifo_stage: registered WIDTH-bit FIFO buffer ahead of the byte bypass stage.
// Ports: clk, rst_n (async active-low), Input_Valid/Input_Ready/Input_Data (producer side),
//        Output_Valid/Output_Ready/Output_Data (consumer side, first-word-fall-through),
//        Count (stored entries, 0..DEPTH). All outputs are driven from registered state only.
module input_fifo_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Input_Valid,
    output logic                       Input_Ready,
    input  logic [WIDTH-1:0]           Input_Data,
    output logic                       Output_Valid,
    input  logic                       Output_Ready,
    output logic [WIDTH-1:0]           Output_Data,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push, pop;

    // Handshake qualifiers use the state-only ready/valid, so a full
    // stage refuses a push even when a pop happens in the same cycle.
    assign Input_Ready  = (count_q != CW'(DEPTH));
    assign Output_Valid = (count_q != '0);
    assign Output_Data  = mem_q[rd_ptr_q];
    assign Count        = count_q;

    assign push = Input_Valid  && Input_Ready;
    assign pop  = Output_Valid && Output_Ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap from DEPTH-1 to 0 by natural overflow.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so Output_Data reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= Input_Data;
        end
    end

endmodule
